blink_rate_decoder: RTL

Receive-side counterpart of the switch-rate LED blinker. It samples a toggling signal produced by a blinker with the same `WIDTH`/`N`, measures the clock-cycle interval between toggles, and recovers the 3-bit rate code that drove the blinker (1..7). It sits on board-to-board or loopback test paths, where it reports the decoded rate, lock status and errors to status logic.

---
 rtl/blink_pkg.sv | 18 +
 rtl/blink_edge_sync.sv | 67 ++++++
 rtl/blink_rate_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink-rate decoder and the blinker's bench model.
package blink_pkg;

    localparam int RATE_MAX = 7;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StConfirm,
        StLocked
    } dec_state_e;

    // Expected half-period in cycles for rate code k: ceil(n/k) + 1.
    function automatic int unsigned half_period(input int unsigned n, input int unsigned k);
        return (n + k - 1) / k + 1;
    endfunction

endpackage

// File: rtl/blink_edge_sync.sv
// Synchronizes sig_i, optionally filters glitches (BLINK_DEC_GLITCH_FILTER_EN), and
// emits a one-cycle pulse on every rising or falling edge of the resulting level.
module blink_edge_sync #(
    parameter int unsigned FILT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic edge_o
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       level;

`ifdef BLINK_DEC_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [3:0] run_q, run_d;

    // run_q counts consecutive samples that disagree with the filtered level.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (run_q == 4'(FILT - 1)) begin
                filt_d = sync_q[1];
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign level = filt_q;
`else
    logic unused_filt;
    assign unused_filt = (FILT != 0);
    assign level       = sync_q[1];
`endif

    always_comb begin
        sync_d = {sync_q[0], sig_i};
        prev_d = level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_o = level ^ prev_q;

endmodule

// File: rtl/blink_rate_decoder.sv
// Recovers the 3-bit blinker rate code from the toggle interval of sig_in.
// Optional glitch filter in blink_edge_sync: define BLINK_DEC_GLITCH_FILTER_EN.
module blink_rate_decoder
    import blink_pkg::*;
#(
    parameter int unsigned WIDTH     = 27,
    parameter int unsigned N         = 50_000_000,
    parameter int unsigned TOL_SHIFT = 4,
    parameter int unsigned FILT      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sig_in,
    output logic [2:0]     rate,
    output logic           valid,
    output logic [WIDTH:0] period,
    output logic           err,
    output logic           stall
);

    localparam int unsigned CntW = WIDTH + 1;
    localparam int unsigned WinW = WIDTH + 2;
    localparam logic [CntW-1:0] Tmo = CntW'(2 * half_period(N, 1));

    logic             sig_edge;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  period_q, period_d;
    logic [2:0]       rate_q, rate_d;
    logic [2:0]       conf_q, conf_d;
    logic             err_q, err_d;
    dec_state_e       state_q, state_d;
    logic [2:0]       cls;
    logic [WinW-1:0]  win_lo [1:RATE_MAX];
    logic [WinW-1:0]  win_hi [1:RATE_MAX];

    blink_edge_sync #(
        .FILT (FILT)
    ) u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sig_in),
        .edge_o (sig_edge)
    );

    // Windows are one bit wider than the counter so P + tol cannot wrap.
    for (genvar k = 1; k <= RATE_MAX; k++) begin : g_win
        localparam int unsigned Pk = half_period(N, k);
        assign win_lo[k] = WinW'(Pk - (Pk >> TOL_SHIFT));
        assign win_hi[k] = WinW'(Pk + (Pk >> TOL_SHIFT));
    end

    // Descending scan so the lowest matching code wins; 0 means unclassifiable.
    always_comb begin
        cls = '0;
        for (int k = RATE_MAX; k >= 1; k--) begin
            if ({1'b0, cnt_q} >= win_lo[k] && {1'b0, cnt_q} <= win_hi[k]) begin
                cls = 3'(k);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sig_edge) begin
            cnt_d = CntW'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        conf_d   = conf_q;
        rate_d   = rate_q;
        period_d = period_q;
        err_d    = 1'b0;
        stall    = 1'b0;
        if (sig_edge) begin
            if (state_q != StIdle) begin
                period_d = cnt_q;
            end
            case (state_q)
                StIdle: state_d = StMeasure;
                StMeasure: begin
                    if (cls == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StConfirm;
                        conf_d  = cls;
                    end
                end
                StConfirm: begin
                    if (cls == '0) begin
                        err_d   = 1'b1;
                        state_d = StMeasure;
                    end else if (cls == conf_q) begin
                        state_d = StLocked;
                        rate_d  = cls;
                    end else begin
                        conf_d = cls;
                    end
                end
                StLocked: begin
                    if (cls == '0) begin
                        err_d   = 1'b1;
                        state_d = StMeasure;
                        rate_d  = '0;
                    end else if (cls != rate_q) begin
                        state_d = StConfirm;
                        conf_d  = cls;
                        rate_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && cnt_q == Tmo) begin
            stall   = 1'b1;
            state_d = StIdle;
            rate_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= '0;
            rate_q   <= '0;
            conf_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            rate_q   <= rate_d;
            conf_q   <= conf_d;
            err_q    <= err_d;
        end
    end

    assign rate   = rate_q;
    assign valid  = (state_q == StLocked);
    assign period = period_q;
    assign err    = err_q;

endmodule
